// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - branch-type encodings and counter helpers for the gshare BTB
package bp_pkg;

  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [1:0] BR_JAL  = 2'b01;
  localparam logic [1:0] BR_JALR = 2'b10;
  localparam logic [1:0] BR_RSVD = 2'b11;

  function automatic int unsigned weak_taken(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned weak_not_taken(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// rtl/sat_counter_next.sv - saturating up/down counter next-state
module sat_counter_next #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != CTR_MAX) next = cur + 1'b1;
    end else begin
      if (cur != '0) next = cur - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_btb_gen.sv
// rtl/gshare_btb_gen.sv - gshare predictor + BTB with speculative GHR and recovery
module gshare_btb_gen
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int GHR_BITS = 5,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         if_pc,
  input  logic                if_fire,
  output logic [31:0]         pred_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic [1:0]          upd_type,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(weak_not_taken(CTR_BITS));

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          type_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_jump, up_hit;
  logic [CTR_BITS-1:0] ctr_next;
  logic                unused_bits;

  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign lk_idx = if_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign lk_tag = if_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
  assign up_tag = upd_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2];

  assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_jump    = (type_q[lk_idx] == BR_JAL) || (type_q[lk_idx] == BR_JALR);
  assign pred_taken = pred_hit && (lk_jump || ctr_q[lk_idx][CTR_BITS-1]);
  assign pred_pc    = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;
  assign pred_ghr   = ghr_q;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter_next #(.CTR_BITS(CTR_BITS)) u_ctr_next (
    .cur   (ctr_q[up_idx]),
    .taken (upd_taken),
    .next  (ctr_next)
  );

  // The truncating cast drops the oldest bit, which also covers GHR_BITS == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (if_fire && pred_hit && type_q[lk_idx] == BR_COND)
      ghr_d = GHR_BITS'({ghr_q, pred_taken});
    if (upd_valid && upd_mispredict)
      ghr_d = (upd_type == BR_COND) ? GHR_BITS'({upd_ghr, upd_taken}) : upd_ghr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q            <= '0;
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (if_fire) stat_lookups <= stat_lookups + 32'd1;
      if (upd_valid && upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= BR_COND;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid && upd_type != BR_RSVD) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
          type_q[up_idx]   <= upd_type;
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        type_q[up_idx]   <= upd_type;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_gen.sv
// tb/tb_gshare_btb_gen.sv - scoreboard bench for gshare_btb_gen with directed vectors
module tb_gshare_btb_gen;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_fire;
  logic [31:0] pred_pc;
  logic        pred_hit, pred_taken;
  logic [4:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [4:0]  upd_ghr;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_lookups, stat_mispredicts;

  gshare_btb_gen dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_fire(if_fire),
    .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_stat;
    logic        hit, taken;
    logic [31:0] pc;
    logic [4:0]  ghr;
    logic [31:0] lk, mp;
  } exp_t;

  exp_t exp_q[$];
  logic chk = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: drains every expectation queued for the cycle being sampled.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) cmp("scoreboard_empty", 32'd0, 32'd1);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_stat) begin
          cmp({e.name, ".lookups"}, stat_lookups, e.lk);
          cmp({e.name, ".mispredicts"}, stat_mispredicts, e.mp);
        end else begin
          cmp({e.name, ".hit"}, 32'(pred_hit), 32'(e.hit));
          cmp({e.name, ".taken"}, 32'(pred_taken), 32'(e.taken));
          cmp({e.name, ".pc"}, pred_pc, e.pc);
          cmp({e.name, ".ghr"}, 32'(pred_ghr), 32'(e.ghr));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic exp_pred(input string n, input logic [31:0] pc, input logic h, input logic t,
                          input logic [31:0] ppc, input logic [4:0] g);
    exp_t e;
    if_pc = pc;
    e = '{name: n, is_stat: 1'b0, hit: h, taken: t, pc: ppc, ghr: g, lk: 0, mp: 0};
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic exp_stat(input string n, input logic [31:0] lk, input logic [31:0] mp);
    exp_t e;
    e = '{name: n, is_stat: 1'b1, hit: 0, taken: 0, pc: 0, ghr: 0, lk: lk, mp: mp};
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic set_upd(input logic [1:0] ty, input logic [31:0] pc, input logic [4:0] g,
                         input logic tk, input logic [31:0] tgt, input logic misp);
    upd_valid = 1'b1; upd_type = ty; upd_pc = pc; upd_ghr = g;
    upd_taken = tk; upd_target = tgt; upd_mispredict = misp;
  endtask

  task automatic clr_upd();
    upd_valid = 1'b0; upd_type = BR_COND; upd_pc = '0; upd_ghr = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
  endtask

  task automatic train(input logic [1:0] ty, input logic [31:0] pc, input logic [4:0] g,
                       input logic tk, input logic [31:0] tgt, input logic misp);
    set_upd(ty, pc, g, tk, tgt, misp);
    tick();
    clr_upd();
  endtask

  initial begin
    reset = 1'b1; if_fire = 1'b0; if_pc = 32'h100; clr_upd();
    repeat (3) tick();
    reset = 1'b0;
    exp_pred("reset", 32'h100, 0, 0, 32'h104, 5'd0);
    exp_stat("reset_stat", 0, 0);
    tick();

    train(BR_JAL, 32'h100, 5'd0, 1, 32'h200, 0);
    exp_pred("jal_hit", 32'h100, 1, 1, 32'h200, 5'd0);
    tick();

    // Counter sweep on the branch at 0x40 (index 16, tag 0)
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);
    exp_pred("alloc_wt", 32'h40, 1, 1, 32'h80, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    exp_pred("nt1", 32'h40, 1, 0, 32'h44, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    exp_pred("nt2", 32'h40, 1, 0, 32'h44, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);
    exp_pred("floor", 32'h40, 1, 0, 32'h44, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);
    train(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    exp_pred("sat_hi", 32'h40, 1, 1, 32'h80, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    exp_pred("sat_hi_nt", 32'h40, 1, 0, 32'h44, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 1, 32'h80, 0);

    // Speculative shift, then recovery overriding a concurrent shift
    if_fire = 1'b1;
    exp_pred("spec1", 32'h40, 1, 1, 32'h80, 5'd0); tick();
    set_upd(BR_COND, 32'h300, 5'd0, 0, 32'h0, 1);
    exp_pred("spec2", 32'h44, 1, 1, 32'h80, 5'd1); tick();
    clr_upd(); if_fire = 1'b0;
    exp_pred("recover_cond", 32'h40, 1, 1, 32'h80, 5'd0);
    exp_stat("stat_spec", 2, 1);
    tick();
    train(BR_JAL, 32'h300, 5'h15, 1, 32'h400, 1);
    exp_pred("recover_jal", 32'h300, 1, 1, 32'h400, 5'h15);
    exp_stat("stat_jal", 2, 2);
    tick();
    train(BR_JAL, 32'h100, 5'd0, 1, 32'h200, 1);
    exp_pred("recover_zero", 32'h100, 1, 1, 32'h200, 5'd0); tick();

    // Same-index lookup and update
    set_upd(BR_COND, 32'h40, 5'd0, 1, 32'h90, 0);
    exp_pred("same_old_tgt", 32'h40, 1, 1, 32'h80, 5'd0); tick();
    clr_upd();
    exp_pred("same_new_tgt", 32'h40, 1, 1, 32'h90, 5'd0); tick();
    train(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    set_upd(BR_COND, 32'h40, 5'd0, 0, 32'h0, 0);
    exp_pred("same_old_ctr", 32'h40, 1, 1, 32'h90, 5'd0); tick();
    clr_upd();
    exp_pred("same_new_ctr", 32'h40, 1, 0, 32'h44, 5'd0); tick();

    // Fourth entry, then reset concurrent with an update
    train(BR_JAL, 32'h20, 5'd0, 1, 32'h600, 0);
    exp_pred("fill4", 32'h20, 1, 1, 32'h600, 5'd0); tick();
    reset = 1'b1;
    set_upd(BR_JAL, 32'h60, 5'd0, 1, 32'h700, 0);
    tick();
    reset = 1'b0; clr_upd();
    exp_pred("rst_e0", 32'h100, 0, 0, 32'h104, 5'd0); tick();
    exp_pred("rst_e1", 32'h40, 0, 0, 32'h44, 5'd0); tick();
    exp_pred("rst_e2", 32'h300, 0, 0, 32'h304, 5'd0); tick();
    exp_pred("rst_e3", 32'h20, 0, 0, 32'h24, 5'd0); tick();
    exp_pred("rst_conc", 32'h60, 0, 0, 32'h64, 5'd0);
    exp_stat("rst_stat2", 0, 0);
    tick();
    if_fire = 1'b1;
    exp_pred("pc_wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 5'd0); tick();
    if_fire = 1'b0;
    exp_stat("stat_after_fire", 1, 0);
    tick();

    tick();
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gshare_btb_gen.md
Name: gshare_btb_gen

Overview:
Parametrised gshare branch predictor and branch target buffer for the pipelined RV32I core. It performs a same-cycle lookup in IF and returns the predicted next PC plus the history snapshot used for that lookup. Resolved control-flow outcomes arrive from EX and train the table. The block keeps a speculative global history register (GHR) and restores it on mispredict; it also keeps tagged valid entries, stored branch type, N-bit saturating counters and performance counters.

Parameters:
IDX_BITS, 5, log2 of entry count (ENTRIES = 2**IDX_BITS).
GHR_BITS, 5, global history length; must satisfy 1 <= GHR_BITS <= IDX_BITS.
CTR_BITS, 2, saturating counter width; must be >= 1.
TAG_BITS, 25, stored tag width; must satisfy TAG_BITS <= 30-IDX_BITS.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
if_pc  in  32  PC being fetched
if_fire  in  1  fetch advances this cycle (not stalled or flushed)
pred_pc  out  32  predicted next PC
pred_hit  out  1  valid tag match at lookup index
pred_taken  out  1  prediction redirects fetch
pred_ghr  out  GHR_BITS  speculative GHR used for this lookup; travels down the pipe
upd_valid  in  1  EX resolves a control-flow instruction
upd_pc  in  32  PC of resolved instruction
upd_ghr  in  GHR_BITS  pred_ghr snapshot carried with that instruction
upd_type  in  2  00 cond branch, 01 jal, 10 jalr, 11 reserved (ignored)
upd_taken  in  1  actual direction (1 for jal/jalr)
upd_target  in  32  actual target (pc+imm or rs1+imm)
upd_mispredict  in  1  pipeline flushes due to this instruction
stat_lookups  out  32  count of if_fire cycles
stat_mispredicts  out  32  count of upd_valid && upd_mispredict

Behaviour:
- Lookup index: if_pc[IDX_BITS+1:2] XOR zero-extended GHR. Tag: if_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2]. Update index and tag use upd_pc and upd_ghr the same way.
- Entry fields: valid, tag, target[31:0], type[1:0], ctr[CTR_BITS-1:0].
- Lookup is combinational with zero latency. pred_hit = valid && tag match.
- pred_taken = pred_hit && (type is jal/jalr || ctr MSB == 1).
- pred_pc = pred_taken ? target : if_pc+4, with 32-bit wrap. pred_ghr = current speculative GHR.
- Speculative GHR: on if_fire && pred_hit && type == branch, GHR <= {GHR[GHR_BITS-2:0], pred_taken}. If GHR_BITS == 1, GHR <= pred_taken.
- Recovery: on upd_valid && upd_mispredict:
  - cond branch: GHR <= {upd_ghr shifted left by 1, upd_taken}.
  - otherwise: GHR <= upd_ghr.
  - Recovery overrides a speculative shift in the same cycle.
- Training, on upd_valid with upd_type != 11, applied at the clock edge:
  - Hit: ctr saturating-increments if taken, else saturating-decrements. Counter rails are 0 and 2**CTR_BITS-1. If taken, target <= upd_target and type <= upd_type.
  - Miss and taken: allocate and overwrite. Set valid=1, tag, target, type, and ctr = weak-taken (1 << (CTR_BITS-1)).
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the new contents are visible next cycle.
- Reset (synchronous, takes priority over everything):
  - All valid bits cleared; all ctr = weak-not-taken ((1 << (CTR_BITS-1)) - 1); targets and tags set to 0.
  - GHR = 0; both stat counters = 0.
  - Outputs after reset: pred_hit = 0, pred_taken = 0, pred_ghr = 0, pred_pc = if_pc+4.
  - Reset asserted mid-operation discards any concurrent update.
- Stat counters wrap at 2**32 without saturation.

Decomposition:
- Shared package bp_pkg holds the branch-type encodings (BR_COND, BR_JAL, BR_JALR) and the helper functions for weak-taken and weak-not-taken counter values.
- One sub-module, sat_counter_next: combinational next-state for a CTR_BITS counter (inputs cur, taken; output next). It is instantiated once, on the update path.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_pc=0x104, pred_ghr=0.
- Update jal upd_pc=0x100, upd_ghr=0, upd_target=0x200, taken=1; next cycle if_pc=0x100 with GHR=0 -> pred_hit=1, pred_pc=0x200, pred_taken=1.
- Counter sweep on branch 0x40 (ghr 0):
  - Taken-allocate -> ctr=10, pred_pc=target.
  - Two not-taken updates -> ctr=00, pred_pc=0x44.
  - Four taken updates -> ctr saturates at 11.
- Speculative GHR: hit taken branch with if_fire -> GHR=00001. Same cycle as a second fired predicted branch, apply upd_mispredict cond branch with upd_ghr=00000, taken=0 -> GHR=00000 next cycle; stat_mispredicts increments by 1.
- Same-index lookup and update in one cycle: the lookup sees the old ctr/target that cycle and the new values the following cycle.
- Fill 4 entries, assert reset for 1 cycle during upd_valid -> all lookups miss, GHR=0, stats=0, no entry from the concurrent update.
